pipeline_sink: RTL

//  Terminal consumer for the address/id/valid + stall pipeline chain. Sits after
//  the last pipeline_stage: accepts its out_address/out_id/out_valid and drives

---
 rtl/pipeline_sink.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pipeline_sink.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_sink
//  Purpose  : Terminal consumer of the address/id/valid + stall pipeline.
//             Buffers accepted requests in a first-word-fall-through FIFO,
//             drains them through a valid/ready response port, checks the
//             id sequence and counts accepts (saturating).
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_sink #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int ID_WIDTH      = 8,
    parameter int DEPTH         = 4,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDRESS_WIDTH-1:0]   in_address,
    input  logic [ID_WIDTH-1:0]        in_id,
    input  logic                       in_valid,
    output logic                       out_stall,
    output logic [ADDRESS_WIDTH-1:0]   rsp_address,
    output logic [ID_WIDTH-1:0]        rsp_id,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    input  logic                       clear_stats,
    output logic [COUNT_WIDTH-1:0]     accepted_count,
    output logic                       seq_error,
    output logic [ID_WIDTH-1:0]        seq_error_id,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int                  c_PTR_W      = $clog2(DEPTH);
    localparam int                  c_OCC_W      = c_PTR_W + 1;
    localparam logic [c_OCC_W-1:0]  c_FULL_LEVEL = c_OCC_W'(DEPTH);
    localparam logic [c_OCC_W-1:0]  c_OCC_ONE    = c_OCC_W'(1);
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE    = c_PTR_W'(1);
    localparam logic [ID_WIDTH-1:0] c_ID_ONE     = ID_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] c_CNT_ONE = COUNT_WIDTH'(1);

    // Storage and bookkeeping
    logic [ADDRESS_WIDTH-1:0] r_mem_addr [DEPTH];
    logic [ID_WIDTH-1:0]      r_mem_id   [DEPTH];
    logic [c_PTR_W-1:0]       r_wr_ptr;
    logic [c_PTR_W-1:0]       r_rd_ptr;
    logic [c_OCC_W-1:0]       r_occupancy;
    logic [COUNT_WIDTH-1:0]   r_accepted_count;
    logic                     r_seq_error;
    logic [ID_WIDTH-1:0]      r_seq_error_id;
    logic [ID_WIDTH-1:0]      r_expected_id;

    logic w_full;
    logic w_nonempty;
    logic w_accept;
    logic w_pop;
    logic w_id_match;

    // Stall and valid are decoded purely from the registered occupancy so
    // that neither in_valid nor rsp_ready can reach out_stall combinationally.
    assign w_full     = (r_occupancy == c_FULL_LEVEL);
    assign w_nonempty = (r_occupancy != '0);
    assign w_accept   = in_valid && !w_full;
    assign w_pop      = w_nonempty && rsp_ready;
    assign w_id_match = (in_id == r_expected_id);

    assign out_stall      = w_full;
    assign rsp_valid      = w_nonempty;
    assign rsp_address    = w_nonempty ? r_mem_addr[r_rd_ptr] : '0;
    assign rsp_id         = w_nonempty ? r_mem_id[r_rd_ptr]   : '0;
    assign occupancy      = r_occupancy;
    assign accepted_count = r_accepted_count;
    assign seq_error      = r_seq_error;
    assign seq_error_id   = r_seq_error_id;

    // Write accepted requests into the slot at the write pointer
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem_addr[r_wr_ptr] <= in_address;
            r_mem_id[r_wr_ptr]   <= in_id;
        end
    end

    // Pointer and occupancy tracking; reset discards everything buffered
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_occupancy <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_accept, w_pop})
                2'b10:   r_occupancy <= r_occupancy + c_OCC_ONE;
                2'b01:   r_occupancy <= r_occupancy - c_OCC_ONE;
                default: r_occupancy <= r_occupancy;
            endcase
        end
    end

    // Saturating accept counter; clear takes priority over an increment
    always_ff @(posedge clk) begin
        if (reset) begin
            r_accepted_count <= '0;
        end else if (clear_stats) begin
            r_accepted_count <= '0;
        end else if (w_accept && (r_accepted_count != '1)) begin
            r_accepted_count <= r_accepted_count + c_CNT_ONE;
        end
    end

    // Id sequence checking: the expected id always resyncs to the accepted
    // id + 1 (identical to expected + 1 on a match); clear only touches the
    // error flags, never the expected id.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_expected_id  <= '0;
            r_seq_error    <= 1'b0;
            r_seq_error_id <= '0;
        end else begin
            if (w_accept) begin
                r_expected_id <= in_id + c_ID_ONE;
            end
            if (clear_stats) begin
                r_seq_error    <= 1'b0;
                r_seq_error_id <= '0;
            end else if (w_accept && !w_id_match) begin
                r_seq_error <= 1'b1;
                if (!r_seq_error) begin
                    r_seq_error_id <= in_id;
                end
            end
        end
    end

endmodule
`default_nettype wire
